// File: rtl/vga_pkg.sv
// Shared constants and FSM state type for the VGA layer compositor.
// Defaults carry a _DEF suffix so modules can expose same-named parameters.
package vga_pkg;
    localparam int          N_LAYERS_DEF = 20;
    localparam int          COLOR_W_DEF  = 12;
    localparam int          CNT_W_DEF    = 16;
    localparam logic [11:0] TRANSP_DEF   = 12'h000;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } state_t;
endpackage

// File: rtl/vga_prio_enc.sv
// Combinational lowest-index-first priority encoder.
// Produces the index of the first set request bit and a hit flag.
module vga_prio_enc #(
    parameter int N     = 20,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             hit
);
    // Scan from the top so the lowest set index is the last assignment.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vga_layer_arbiter.sv
// Priority compositor for per-object VGA layers: lowest-index opaque enabled layer wins,
// with frame-synchronous layer enables and per-frame collision statistics.
module vga_layer_arbiter
    import vga_pkg::*;
#(
    parameter int          N_LAYERS = N_LAYERS_DEF,
    parameter int          COLOR_W  = COLOR_W_DEF,
    parameter logic [COLOR_W-1:0] TRANSP = TRANSP_DEF,
    parameter int          CNT_W    = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_LAYERS*COLOR_W-1:0]   layer_px,
    input  logic                          pix_valid,
    input  logic                          vsync_pulse,
    input  logic                          cfg_we,
    input  logic [N_LAYERS-1:0]           cfg_mask,
    output logic                          cfg_pending,
    output logic [COLOR_W-1:0]            out_rgb,
    output logic                          out_valid,
    output logic                          out_hit,
    output logic [$clog2(N_LAYERS)-1:0]   out_layer,
    output logic [CNT_W-1:0]              coll_count
);
    localparam int IDX_W = $clog2(N_LAYERS);

    state_t                        state_reg;
    logic [N_LAYERS-1:0]           active_reg;
    logic [N_LAYERS-1:0]           shadow_reg;
    logic [N_LAYERS*COLOR_W-1:0]   px_reg;
    logic [N_LAYERS-1:0]           opaque_next;
    logic [N_LAYERS-1:0]           opaque_reg;
    logic                          s1_valid_reg;
    logic [CNT_W-1:0]              coll_cnt_reg;

    logic [IDX_W-1:0]              win_idx;
    logic                          win_hit;
    logic [COLOR_W-1:0]            win_px;
    logic                          coll_now;
    logic [CNT_W-1:0]              coll_cnt_next;

    for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_opaque
        assign opaque_next[gi] = active_reg[gi] & (layer_px[gi*COLOR_W +: COLOR_W] != TRANSP);
    end

    vga_prio_enc #(
        .N     (N_LAYERS),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req (opaque_reg),
        .idx (win_idx),
        .hit (win_hit)
    );

    assign win_px = px_reg[win_idx*COLOR_W +: COLOR_W];

    // Two or more opaque layers: clearing the lowest set bit leaves something behind.
    assign coll_now = s1_valid_reg && ((opaque_reg & (opaque_reg - N_LAYERS'(1))) != '0);

    always_comb begin
        coll_cnt_next = coll_cnt_reg;
        if (coll_now && (coll_cnt_reg != '1)) begin
            coll_cnt_next = coll_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= WAIT_FRAME;
            active_reg   <= '1;
            shadow_reg   <= '1;
            cfg_pending  <= 1'b0;
            px_reg       <= '0;
            opaque_reg   <= '0;
            s1_valid_reg <= 1'b0;
            out_rgb      <= '0;
            out_valid    <= 1'b0;
            out_hit      <= 1'b0;
            out_layer    <= '0;
            coll_cnt_reg <= '0;
            coll_count   <= '0;
        end else begin
            if (vsync_pulse) begin
                state_reg <= RUN;
            end

            // A write coincident with vsync lands in the shadow and waits a full frame.
            if (vsync_pulse) begin
                active_reg  <= shadow_reg;
                cfg_pending <= cfg_we;
            end else if (cfg_we) begin
                cfg_pending <= 1'b1;
            end
            if (cfg_we) begin
                shadow_reg <= cfg_mask;
            end

            px_reg       <= layer_px;
            opaque_reg   <= opaque_next;
            s1_valid_reg <= pix_valid && (state_reg == RUN);

            out_valid <= s1_valid_reg;
            out_hit   <= s1_valid_reg && win_hit;
            out_layer <= (s1_valid_reg && win_hit) ? win_idx : '0;
            out_rgb   <= (s1_valid_reg && win_hit) ? win_px : '0;

            if (vsync_pulse) begin
                coll_count   <= coll_cnt_next;
                coll_cnt_reg <= '0;
            end else begin
                coll_cnt_reg <= coll_cnt_next;
            end
        end
    end
endmodule

// File: tb/tb_vga_layer_arbiter.sv
// Directed plus randomized bench for vga_layer_arbiter against a per-pixel reference model
// that resolves each pixel directly from layer rules and delays the answer by two clocks.
module tb_vga_layer_arbiter;
    localparam int NL = 20;
    localparam int CW = 12;

    typedef struct packed {
        logic       valid;
        logic       hit;
        logic [4:0] layer;
        logic [11:0] rgb;
    } res_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NL*CW-1:0]  layer_px;
    logic              pix_valid;
    logic              vsync_pulse;
    logic              cfg_we;
    logic [NL-1:0]     cfg_mask;
    logic              cfg_pending;
    logic [CW-1:0]     out_rgb;
    logic              out_valid;
    logic              out_hit;
    logic [4:0]        out_layer;
    logic [15:0]       coll_count;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    res_t        m_s1, m_out;
    logic [NL-1:0] m_active, m_shadow;
    logic        m_pending, m_run, m_pend_coll;
    int          m_cnt, m_coll;

    always #5 clk = ~clk;

    vga_layer_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .layer_px    (layer_px),
        .pix_valid   (pix_valid),
        .vsync_pulse (vsync_pulse),
        .cfg_we      (cfg_we),
        .cfg_mask    (cfg_mask),
        .cfg_pending (cfg_pending),
        .out_rgb     (out_rgb),
        .out_valid   (out_valid),
        .out_hit     (out_hit),
        .out_layer   (out_layer),
        .coll_count  (coll_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner = first enabled layer whose pixel is not the transparent key.
    function automatic res_t resolve(input logic [NL*CW-1:0] px, input logic v,
                                     input logic [NL-1:0] act, output bit coll);
        res_t r;
        int   n;
        r = '0;
        n = 0;
        for (int i = 0; i < NL; i++) begin
            if (act[i] && px[i*CW +: CW] != 12'h000) begin
                n++;
                if (n == 1) begin
                    r.hit   = 1'b1;
                    r.layer = 5'(i);
                    r.rgb   = px[i*CW +: CW];
                end
            end
        end
        coll = v && (n >= 2);
        if (!v) r = '0;
        else    r.valid = 1'b1;
        return r;
    endfunction

    task automatic model_edge();
        bit   c;
        int   csum;
        res_t r;
        if (rst) begin
            m_s1 = '0; m_out = '0; m_cnt = 0; m_coll = 0; m_pend_coll = 1'b0;
            m_run = 1'b0; m_active = '1; m_shadow = '1; m_pending = 1'b0;
        end else begin
            r = resolve(layer_px, pix_valid && m_run, m_active, c);
            m_out = m_s1;
            m_s1  = r;
            csum  = m_pend_coll ? ((m_cnt < 65535) ? m_cnt + 1 : 65535) : m_cnt;
            if (vsync_pulse) begin m_coll = csum; m_cnt = 0; end
            else             m_cnt = csum;
            m_pend_coll = c;
            if (vsync_pulse) begin
                m_active  = m_shadow;
                m_pending = cfg_we;
                m_run     = 1'b1;
            end else if (cfg_we) begin
                m_pending = 1'b1;
            end
            if (cfg_we) m_shadow = cfg_mask;
        end
    endtask

    task automatic check_all();
        chk("out_valid",   32'(out_valid),   32'(m_out.valid));
        chk("out_hit",     32'(out_hit),     32'(m_out.hit));
        chk("out_layer",   32'(out_layer),   32'(m_out.layer));
        chk("out_rgb",     32'(out_rgb),     32'(m_out.rgb));
        chk("cfg_pending", 32'(cfg_pending), 32'(m_pending));
        chk("coll_count",  32'(coll_count),  32'(m_coll));
    endtask

    task automatic step(input logic v, input logic vs, input logic we, input logic [NL-1:0] m);
        pix_valid = v; vsync_pulse = vs; cfg_we = we; cfg_mask = m;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_layers(input int a, input logic [11:0] ca, input int b, input logic [11:0] cb);
        layer_px = '0;
        if (a >= 0) layer_px[a*CW +: CW] = ca;
        if (b >= 0) layer_px[b*CW +: CW] = cb;
    endtask

    initial begin
        logic [NL-1:0] mask_no3;
        mask_no3 = '1;
        mask_no3[3] = 1'b0;
        rst = 1'b1; layer_px = '0; pix_valid = 0; vsync_pulse = 0; cfg_we = 0; cfg_mask = '0;
        m_s1 = '0; m_out = '0; m_cnt = 0; m_coll = 0; m_pend_coll = 0;
        m_run = 0; m_active = '1; m_shadow = '1; m_pending = 0;
        @(negedge clk);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_pending", 32'(cfg_pending), 0);
        rst = 1'b0;

        // Pixels before the first frame start are ignored.
        set_layers(3, 12'hF00, 7, 12'h0F0);
        repeat (4) step(1, 0, 0, '0);
        chk("prevsync_valid", 32'(out_valid), 0);

        step(0, 1, 0, '0);
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        chk("t1_rgb", 32'(out_rgb), 32'h0F00);
        chk("t1_layer", 32'(out_layer), 3);

        set_layers(-1, 0, -1, 0);
        repeat (3) step(1, 0, 0, '0);
        chk("t2_hit", 32'(out_hit), 0);

        // Mid-frame mask write stays pending until the next vsync.
        set_layers(3, 12'hF00, 7, 12'h0F0);
        step(1, 0, 1, mask_no3);
        repeat (3) step(1, 0, 0, '0);
        chk("t3_still_f00", 32'(out_rgb), 32'h0F00);
        step(0, 1, 0, '0);
        repeat (3) step(1, 0, 0, '0);
        chk("t3_rgb", 32'(out_rgb), 32'h00F0);
        chk("t3_layer", 32'(out_layer), 7);

        // Write coincident with vsync only takes effect one frame later.
        step(1, 0, 1, '1);
        step(0, 1, 1, mask_no3);
        chk("t4_pending", 32'(cfg_pending), 1);
        repeat (3) step(1, 0, 0, '0);
        chk("t4_old_shadow", 32'(out_layer), 3);
        step(0, 1, 0, '0);
        repeat (3) step(1, 0, 0, '0);
        chk("t4_new_mask", 32'(out_layer), 7);

        // Collision statistics, then saturation.
        step(0, 1, 1, '1);
        step(0, 1, 0, '0);
        repeat (100) step(1, 0, 0, '0);
        step(0, 1, 0, '0);
        chk("t5_count100", 32'(coll_count), 100);
        set_layers(3, 12'hF00, -1, 0);
        repeat (50) step(1, 0, 0, '0);
        step(0, 1, 0, '0);
        chk("t5_count0", 32'(coll_count), 0);
        set_layers(3, 12'hF00, 7, 12'h0F0);
        repeat (70000) step(1, 0, 0, '0);
        step(0, 1, 0, '0);
        chk("t5_sat", 32'(coll_count), 32'hFFFF);

        // Randomized traffic with occasional frame starts, config writes and resets.
        for (int n = 0; n < 3000; n++) begin
            logic vs, v, we;
            for (int i = 0; i < NL; i++)
                layer_px[i*CW +: CW] = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(1, 4095)) : 12'h000;
            vs  = ($urandom_range(0, 49) == 0);
            v   = vs ? 1'b0 : ($urandom_range(0, 4) != 0);
            we  = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step(v, vs, we, NL'($urandom));
        end
        rst = 1'b0;

        // Reset mid-frame clears outputs and waits for a new frame start.
        step(0, 1, 0, '0);
        set_layers(3, 12'hF00, 7, 12'h0F0);
        repeat (3) step(1, 0, 0, '0);
        rst = 1'b1;
        step(1, 0, 0, '0);
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_rgb", 32'(out_rgb), 0);
        rst = 1'b0;
        repeat (4) step(1, 0, 0, '0);
        chk("t6_wait_valid", 32'(out_valid), 0);
        step(0, 1, 0, '0);
        repeat (3) step(1, 0, 0, '0);
        chk("t6_resume", 32'(out_rgb), 32'h0F00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
